td4_gen_core: RTL
=================

Name: td4_gen_core

Overview:
- Parametrised next-generation TD4 core: configurable data width and program-counter width.
- Built-in step-rate divider replaces the ad-hoc top-level divider.
- Registered carry flag with no combinational latch.
- Explicit fetch/execute state machine, run/pause control and halt detection.
- Instruction memory is external to the core (combinational ROM on imem_addr_o/imem_data_i), so programs are swappable without touching the core.

Parameters:
- DATA_W, 4: width of registers A, B, OUT, immediate and ALU.
- PC_W, 4: program-counter width; instruction memory depth is 2**PC_W.
- TICK_DIV, 1: clocks per step tick (1 = every clock); must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- run_i  in  1  1 = execute; 0 = freeze at the next tick boundary
- imem_addr_o  out  PC_W  instruction address (equals the PC)
- imem_data_i  in  4+DATA_W  instruction {op[3:0], im[DATA_W-1:0]}; combinational ROM
- in_i  in  DATA_W  input port
- out_o  out  DATA_W  output-port register
- pc_o  out  PC_W  current PC
- carry_o  out  1  registered carry flag
- halted_o  out  1  core halted on a self-jump

Behaviour:
- Reset (rst=0, asynchronous): A, B, out_o, pc_o, carry_o, halted_o, IR and the tick counter all go to 0; state goes to FETCH.
  - Reset release is synchronous to clk.
  - Reset mid-instruction discards IR.
- Tick generator: the counter counts 0..TICK_DIV-1, and tick=1 in the cycle where it reaches TICK_DIV-1 (then wraps to 0). With TICK_DIV=1, tick is high every cycle. The counter runs regardless of run_i.
- State machine: all states advance only on tick && run_i.
  - FETCH: IR <= imem_data_i; go to EXEC.
  - EXEC: execute IR, update PC; go to FETCH, or to HALT if a halt is detected.
  - HALT: no state change, halted_o=1; leave only via reset.
  - With run_i=0, all architectural state holds and the tick counter keeps running.
- Latency: 2 ticks per instruction; architectural updates are visible the cycle after the EXEC tick.
- ISA (im = IR[DATA_W-1:0]; jump target = im[PC_W-1:0], zero-extended if PC_W > DATA_W):
  - 0000 ADD A,im: {C,A} <= A+im
  - 0101 ADD B,im: {C,B} <= B+im
  - 0011 MOV A,im
  - 0111 MOV B,im
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A: A <= in_i
  - 0110 IN B: B <= in_i
  - 1001 OUT B: out_o <= B
  - 1011 OUT im: out_o <= im
  - 1111 JMP im
  - 1110 JNC im: jump if C==0
  - All other opcodes: NOP.
- Carry: ADD writes the carry-out (DATA_W+1-bit sum, wrap modulo 2**DATA_W). Every other executed instruction clears C to 0. JNC tests the C value from before the current instruction.
- PC: jump taken -> PC <= target; otherwise PC <= PC+1, wrapping from 2**PC_W-1 to 0.
- Halt detect: a taken jump (JMP, or JNC with C=0) whose target equals the current PC enters HALT.
  - PC and out_o are unchanged.
  - halted_o rises the cycle after that EXEC tick.
- imem_addr_o = pc_o at all times.

Optional Feature:
- Macro: TD4_EXT_ISA_EN.
- Defined: adds three opcodes.
  - 1000 JC im: jump if C==1; a self-target with C==1 halts.
  - 1010 ADD A,B: {C,A} <= A+B.
  - 1100 OUT A: out_o <= A.
- Not defined: 1000, 1010 and 1100 are NOPs (PC+1, C cleared).

Decomposition:
- Package td4_pkg:
  - opcode localparams (OP_ADD_A, OP_ADD_B, OP_MOV_A, OP_MOV_B, OP_MOV_AB, OP_MOV_BA, OP_IN_A, OP_IN_B, OP_OUT_B, OP_OUT_IM, OP_JMP, OP_JNC, OP_JC, OP_ADD_AB, OP_OUT_A);
  - state encoding ST_FETCH / ST_EXEC / ST_HALT.
- One sub-module: td4_tick_gen (parameter TICK_DIV; ports clk, rst, tick_o). Everything else stays in td4_gen_core.

Test Plan:
- Reset, DATA_W=4, PC_W=4, TICK_DIV=1: assert rst=0 mid-EXEC -> next cycle pc_o=0, out_o=0, carry_o=0, halted_o=0; first FETCH happens the cycle after release.
- Program MOV A,0xF; ADD A,0x1; JNC 0x0; OUT 0x5 -> after the ADD, A=0 and C=1; JNC not taken; out_o=0x5 at PC=3 EXEC; pc_o=4.
- Program OUT 0x7; JMP 0x1 -> out_o=0x7; halted_o=1 two ticks later; pc_o stays 1; run_i toggling has no effect.
- TICK_DIV=4, run_i=1: PC increments every 8 clocks. Drop run_i for 12 clocks -> pc_o, A and IR frozen; execution resumes from the same state.
- DATA_W=8, PC_W=6: ADD A,0xFF with A=0x02 -> A=0x01, C=1. JMP 0xC5 -> PC=0x05 (target truncated to PC_W). PC wraps from 0x3F to 0x00.
- Opcode 1010 with A=3, B=4:
  - TD4_EXT_ISA_EN defined -> A=7, C=0.
  - not defined -> A=3, PC+1, C=0.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: shared opcode and state definitions for the TD4 generation core.
// Opcodes OP_JC, OP_ADD_AB and OP_OUT_A only decode when TD4_EXT_ISA_EN is defined.
package td4_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // MOV A,B
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // MOV B,A
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_JC     = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_ADD_AB = 4'b1010;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_OUT_A  = 4'b1100;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } td4_state_e;

endpackage

// File: rtl/td4_tick_gen.sv
// td4_tick_gen: step-rate divider. Pulses tick_o once every TICK_DIV clocks
// (every clock when TICK_DIV = 1). Free-running; only reset stops it.
module td4_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_MAX);

    // Next count: wrap to zero on the terminal count.
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/td4_gen_core.sv
// td4_gen_core: parametrised TD4 processor core with fetch/execute sequencing,
// run/pause control and self-jump halt detection. Instruction ROM is external.
// Optional macro TD4_EXT_ISA_EN adds JC, ADD A,B and OUT A.
//
// state    | meaning
// ST_FETCH | latch imem_data_i into IR on the next step
// ST_EXEC  | execute IR, update PC/registers/carry on the next step
// ST_HALT  | stopped on a taken self-jump; exit only through reset
module td4_gen_core
    import td4_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int PC_W     = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    output logic [PC_W-1:0]     imem_addr_o,
    input  logic [DATA_W+3:0]   imem_data_i,
    input  logic [DATA_W-1:0]   in_i,
    output logic [DATA_W-1:0]   out_o,
    output logic [PC_W-1:0]     pc_o,
    output logic                carry_o,
    output logic                halted_o
);

    logic              tick;
    td4_state_e        st_q,     st_d;
    logic [DATA_W+3:0] ir_q,     ir_d;
    logic [DATA_W-1:0] a_q,      a_d;
    logic [DATA_W-1:0] b_q,      b_d;
    logic [DATA_W-1:0] out_q,    out_d;
    logic [PC_W-1:0]   pc_q,     pc_d;
    logic              c_q,      c_d;
    logic              halted_q, halted_d;

    logic [3:0]        op;
    logic [DATA_W-1:0] im;
    logic [PC_W-1:0]   tgt;
    logic [DATA_W:0]   sum;
    logic              jmp;

    td4_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign op = ir_q[DATA_W+3 -: 4];
    assign im = ir_q[DATA_W-1:0];

    // Jump target: truncate or zero-extend the immediate to the PC width.
    if (PC_W <= DATA_W) begin : g_tgt_trunc
        assign tgt = im[PC_W-1:0];
    end else begin : g_tgt_zext
        assign tgt = {{(PC_W-DATA_W){1'b0}}, im};
    end

    // Next-state and datapath decode; everything holds unless a step fires.
    always_comb begin
        st_d     = st_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        pc_d     = pc_q;
        c_d      = c_q;
        halted_d = halted_q;
        sum      = '0;
        jmp      = 1'b0;
        if (tick && run_i) begin
            case (st_q)
                ST_FETCH: begin
                    ir_d = imem_data_i;
                    st_d = ST_EXEC;
                end
                ST_EXEC: begin
                    st_d = ST_FETCH;
                    c_d  = 1'b0;
                    pc_d = pc_q + PC_W'(1);
                    case (op)
                        OP_ADD_A: begin
                            sum = {1'b0, a_q} + {1'b0, im};
                            a_d = sum[DATA_W-1:0];
                            c_d = sum[DATA_W];
                        end
                        OP_ADD_B: begin
                            sum = {1'b0, b_q} + {1'b0, im};
                            b_d = sum[DATA_W-1:0];
                            c_d = sum[DATA_W];
                        end
                        OP_MOV_A:  a_d   = im;
                        OP_MOV_B:  b_d   = im;
                        OP_MOV_AB: a_d   = b_q;
                        OP_MOV_BA: b_d   = a_q;
                        OP_IN_A:   a_d   = in_i;
                        OP_IN_B:   b_d   = in_i;
                        OP_OUT_B:  out_d = b_q;
                        OP_OUT_IM: out_d = im;
                        OP_JMP:    jmp   = 1'b1;
                        OP_JNC:    jmp   = ~c_q;
`ifdef TD4_EXT_ISA_EN
                        OP_JC:     jmp   = c_q;
                        OP_ADD_AB: begin
                            sum = {1'b0, a_q} + {1'b0, b_q};
                            a_d = sum[DATA_W-1:0];
                            c_d = sum[DATA_W];
                        end
                        OP_OUT_A:  out_d = a_q;
`endif
                        default: ;
                    endcase
                    // A taken jump onto itself can never make progress: park in HALT.
                    if (jmp) begin
                        if (tgt == pc_q) begin
                            pc_d     = pc_q;
                            st_d     = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = tgt;
                        end
                    end
                end
                ST_HALT: ;
                default: st_d = ST_FETCH;
            endcase
        end
    end

    // Architectural and sequencing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= ST_FETCH;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            c_q      <= c_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign out_o       = out_q;
    assign carry_o     = c_q;
    assign halted_o    = halted_q;

endmodule
